// File: rtl/tp8_pkg.sv
// ---------------------------------------------------------------------------
// tp8_pkg
// Shared definitions for the tp8 host GPIO command path: opcodes, command word
// field positions, log FSM state encodings, readback source encodings and the
// STATUS word bit map.
// ---------------------------------------------------------------------------
package tp8_pkg;

    // Opcodes carried in i_gpio[31:24]
    localparam logic [7:0] CMD_RST  = 8'h01;
    localparam logic [7:0] CMD_ENB  = 8'h02;
    localparam logic [7:0] CMD_BERQ = 8'h03;
    localparam logic [7:0] CMD_LOG  = 8'h04;
    localparam logic [7:0] CMD_READ = 8'h05;
    localparam logic [7:0] CMD_BERI = 8'h06;
    localparam logic [7:0] CMD_ADDR = 8'h07;

    // Command word fields
    localparam int OPC_MSB     = 31;
    localparam int OPC_LSB     = 24;
    localparam int STROBE_BIT  = 23;
    localparam int PAYLOAD_MSB = 22;

    // Log FSM states; encoding is reported in the STATUS word
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2,
        ST_READ = 2'd3
    } log_state_t;

    // Readback source select
    typedef enum logic [1:0] {
        SRC_STATUS = 2'd0,
        SRC_BER_Q  = 2'd1,
        SRC_BER_I  = 2'd2,
        SRC_MEM    = 2'd3
    } rb_src_t;

    // STATUS word bit map (address occupies the low NB_ADDR bits)
    localparam int ST_STATE_MSB = 31;
    localparam int ST_STATE_LSB = 30;
    localparam int ST_FULL_BIT  = 29;
    localparam int ST_SRST_BIT  = 28;
    localparam int ST_RX_BIT    = 27;
    localparam int ST_TX_BIT    = 26;
    localparam int ST_PHASE_MSB = 25;
    localparam int ST_PHASE_LSB = 24;

    // Memory readback word: valid flag on top, data in the low bits
    localparam int MEM_VALID_BIT = 31;

endpackage

// File: rtl/log_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// log_ctrl_fsm
// Sequences the log memory through capture and read-out.
//
//   state | meaning
//   IDLE  | memory inactive, waiting for arm or read
//   RUN   | capturing (o_log_run=1) until i_mem_full
//   FULL  | capture finished, waiting for read
//   READ  | host reads the memory (o_log_read=1)
//
// Ports
//   clock, i_reset      system clock, async active-high reset
//   i_soft_reset        forces and holds IDLE while high
//   i_cmd_arm           LOG p0=1 pulse
//   i_cmd_abort         LOG p0=0 pulse
//   i_cmd_read          READ pulse
//   i_mem_full          log memory full flag (used only in RUN)
//   o_log_run           capture enable
//   o_log_read          read mode
//   o_state             current state encoding
// ---------------------------------------------------------------------------
module log_ctrl_fsm
    import tp8_pkg::*;
(
    input  logic       clock,
    input  logic       i_reset,
    input  logic       i_soft_reset,
    input  logic       i_cmd_arm,
    input  logic       i_cmd_abort,
    input  logic       i_cmd_read,
    input  logic       i_mem_full,
    output logic       o_log_run,
    output logic       o_log_read,
    output logic [1:0] o_state
);

    log_state_t r_state;
    log_state_t w_next;

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs decode the registered state, so o_log_run falls on the same
    // edge that moves RUN to FULL.
    always_comb begin
        w_next     = r_state;
        o_log_run  = 1'b0;
        o_log_read = 1'b0;

        if (i_soft_reset) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_cmd_arm)       w_next = ST_RUN;
                    else if (i_cmd_read) w_next = ST_READ;
                end
                ST_RUN: begin
                    // Re-arm is a no-op and READ is refused while capturing
                    if (i_cmd_abort)     w_next = ST_IDLE;
                    else if (i_mem_full) w_next = ST_FULL;
                end
                ST_FULL: begin
                    if (i_cmd_read)       w_next = ST_READ;
                    else if (i_cmd_arm)   w_next = ST_RUN;
                    else if (i_cmd_abort) w_next = ST_IDLE;
                end
                ST_READ: begin
                    if (i_cmd_arm)        w_next = ST_RUN;
                    else if (i_cmd_abort) w_next = ST_IDLE;
                end
                default: w_next = ST_IDLE;
            endcase
        end

        case (r_state)
            ST_RUN:  o_log_run  = 1'b1;
            ST_READ: o_log_read = 1'b1;
            default: ;
        endcase
    end

    assign o_state = r_state;

endmodule

// File: rtl/gpio_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// gpio_cmd_sequencer
// Command decoder/sequencer between the 32-bit host GPIO word and the tp8
// datapath. Strobed commands update control registers (soft reset, tx/rx
// enable, phase, log memory address), drive the log FSM, and choose what is
// returned on o_gpio (STATUS, a BER counter half, or log memory data).
//
// Ports
//   clock          system clock
//   i_reset        async active-high reset
//   i_gpio         {opcode[31:24], strobe[23], payload[22:0]}
//   o_gpio         registered readback word
//   o_soft_reset   datapath soft reset level
//   o_enb_tx       transmitter enable
//   o_enb_rx       receiver enable
//   o_phase        receiver sampling phase
//   o_log_run      log capture enable
//   o_log_read     log read mode
//   o_mem_addr     log memory read address
//   i_mem_data     log memory read data (1-cycle synchronous read)
//   i_mem_full     log memory full flag
//   i_ber_err_i    BER error counter, I branch
//   i_ber_err_q    BER error counter, Q branch
// ---------------------------------------------------------------------------
module gpio_cmd_sequencer
    import tp8_pkg::*;
#(
    parameter int NB_GPIOS = 32,
    parameter int NB_CMD   = 8,
    parameter int NB_ADDR  = 10,
    parameter int NB_LOG   = 11,
    parameter int NB_BER   = 64
)(
    input  logic                clock,
    input  logic                i_reset,
    input  logic [NB_GPIOS-1:0] i_gpio,
    output logic [NB_GPIOS-1:0] o_gpio,
    output logic                o_soft_reset,
    output logic                o_enb_tx,
    output logic                o_enb_rx,
    output logic [1:0]          o_phase,
    output logic                o_log_run,
    output logic                o_log_read,
    output logic [NB_ADDR-1:0]  o_mem_addr,
    input  logic [NB_LOG-1:0]   i_mem_data,
    input  logic                i_mem_full,
    input  logic [NB_BER-1:0]   i_ber_err_i,
    input  logic [NB_BER-1:0]   i_ber_err_q
);

    logic [NB_GPIOS-1:0]   r_gpio_d;
    logic                  r_strobe_dd;
    logic                  r_soft_reset;
    logic                  r_enb_tx;
    logic                  r_enb_rx;
    logic [1:0]            r_phase;
    logic [NB_ADDR-1:0]    r_mem_addr;
    rb_src_t               r_src;
    logic                  r_ber_hi;
    logic [NB_GPIOS-1:0]   r_gpio_out;

    logic                  w_fire;
    logic [NB_CMD-1:0]     w_opcode;
    logic [PAYLOAD_MSB:0]  w_payload;
    logic                  w_cmd_rst;
    logic                  w_cmd_enb;
    logic                  w_cmd_berq;
    logic                  w_cmd_beri;
    logic                  w_cmd_log;
    logic                  w_cmd_read;
    logic                  w_cmd_addr;
    logic [1:0]            w_state;
    logic [NB_GPIOS-1:0]   w_status;
    logic [NB_GPIOS-1:0]   w_mem_word;
    logic [NB_GPIOS-1:0]   w_rb;
    logic                  w_unused_payload;

    // Only the strobe bit of the second stage is needed for edge detection.
    // Both stages clear on reset, so a strobe already high at release fires.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            r_gpio_d    <= '0;
            r_strobe_dd <= 1'b0;
        end else begin
            r_gpio_d    <= i_gpio;
            r_strobe_dd <= r_gpio_d[STROBE_BIT];
        end
    end

    assign w_fire    = r_gpio_d[STROBE_BIT] & ~r_strobe_dd;
    assign w_opcode  = r_gpio_d[OPC_MSB:OPC_LSB];
    assign w_payload = r_gpio_d[PAYLOAD_MSB:0];

    assign w_unused_payload = ^w_payload[PAYLOAD_MSB:NB_ADDR];

    always_comb begin
        w_cmd_rst  = 1'b0;
        w_cmd_enb  = 1'b0;
        w_cmd_berq = 1'b0;
        w_cmd_beri = 1'b0;
        w_cmd_log  = 1'b0;
        w_cmd_read = 1'b0;
        w_cmd_addr = 1'b0;
        if (w_fire) begin
            case (w_opcode)
                CMD_RST:  w_cmd_rst  = 1'b1;
                CMD_ENB:  w_cmd_enb  = 1'b1;
                CMD_BERQ: w_cmd_berq = 1'b1;
                CMD_BERI: w_cmd_beri = 1'b1;
                CMD_LOG:  w_cmd_log  = 1'b1;
                CMD_READ: w_cmd_read = 1'b1;
                CMD_ADDR: w_cmd_addr = 1'b1;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            r_soft_reset <= 1'b0;
            r_enb_tx     <= 1'b0;
            r_enb_rx     <= 1'b0;
            r_phase      <= 2'd0;
            r_mem_addr   <= '0;
            r_src        <= SRC_STATUS;
            r_ber_hi     <= 1'b0;
        end else begin
            if (w_cmd_rst) begin
                r_soft_reset <= w_payload[0];
            end
            if (w_cmd_enb) begin
                r_enb_tx <= w_payload[0];
                r_enb_rx <= w_payload[1];
                r_phase  <= w_payload[3:2];
            end
            if (w_cmd_addr) begin
                r_mem_addr <= w_payload[NB_ADDR-1:0];
            end

            if (w_cmd_rst || w_cmd_enb || w_cmd_log || w_cmd_read) begin
                r_src <= SRC_STATUS;
            end else if (w_cmd_berq) begin
                r_src    <= SRC_BER_Q;
                r_ber_hi <= w_payload[0];
            end else if (w_cmd_beri) begin
                r_src    <= SRC_BER_I;
                r_ber_hi <= w_payload[0];
            end else if (w_cmd_addr) begin
                r_src <= SRC_MEM;
            end
        end
    end

    log_ctrl_fsm u_log_ctrl_fsm (
        .clock        (clock),
        .i_reset      (i_reset),
        .i_soft_reset (r_soft_reset),
        .i_cmd_arm    (w_cmd_log & w_payload[0]),
        .i_cmd_abort  (w_cmd_log & ~w_payload[0]),
        .i_cmd_read   (w_cmd_read),
        .i_mem_full   (i_mem_full),
        .o_log_run    (o_log_run),
        .o_log_read   (o_log_read),
        .o_state      (w_state)
    );

    always_comb begin
        w_status = '0;
        w_status[ST_STATE_MSB:ST_STATE_LSB] = w_state;
        w_status[ST_FULL_BIT]               = i_mem_full;
        w_status[ST_SRST_BIT]               = r_soft_reset;
        w_status[ST_RX_BIT]                 = r_enb_rx;
        w_status[ST_TX_BIT]                 = r_enb_tx;
        w_status[ST_PHASE_MSB:ST_PHASE_LSB] = r_phase;
        w_status[NB_ADDR-1:0]               = r_mem_addr;

        w_mem_word = '0;
        w_mem_word[MEM_VALID_BIT]  = 1'b1;
        w_mem_word[NB_LOG-1:0]     = i_mem_data;

        case (r_src)
            SRC_BER_Q: w_rb = r_ber_hi ? i_ber_err_q[2*NB_GPIOS-1:NB_GPIOS]
                                       : i_ber_err_q[NB_GPIOS-1:0];
            SRC_BER_I: w_rb = r_ber_hi ? i_ber_err_i[2*NB_GPIOS-1:NB_GPIOS]
                                       : i_ber_err_i[NB_GPIOS-1:0];
            SRC_MEM:   w_rb = w_mem_word;
            default:   w_rb = w_status;
        endcase
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            r_gpio_out <= '0;
        end else begin
            r_gpio_out <= w_rb;
        end
    end

    assign o_gpio       = r_gpio_out;
    assign o_soft_reset = r_soft_reset;
    assign o_enb_tx     = r_enb_tx;
    assign o_enb_rx     = r_enb_rx;
    assign o_phase      = r_phase;
    assign o_mem_addr   = r_mem_addr;

endmodule
